// File: rtl/tx_fc_arbiter_pkg.sv
// Shared constants, state encoding and credit arithmetic for the TX
// flow-control arbiter.
package tx_fc_arbiter_pkg;

  // Traffic class indices. These are also the bit positions in the
  // request and grant vectors.
  localparam logic [1:0] CLS_P   = 2'd0;
  localparam logic [1:0] CLS_NP  = 2'd1;
  localparam logic [1:0] CLS_CPL = 2'd2;
  localparam int         NUM_CLS = 3;

  // The core reports transmit-available credits when the select is 3'b100.
  localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;

  // One data credit covers this many DW of payload.
  localparam int CREDIT_DW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

  // Data credits needed for a payload of len_dw DW, rounded up.
  // The 11-bit sum cannot overflow, and the result is at most 256, so 9 bits
  // hold it.
  function automatic logic [8:0] data_credits_needed(input logic [9:0] len_dw);
    logic [10:0] sum;
    sum = {1'b0, len_dw} + 11'(CREDIT_DW - 1);
    return 9'(sum / 11'(CREDIT_DW));
  endfunction

  // The round-robin search starts at the class after the one just granted.
  function automatic logic [1:0] next_class(input logic [2:0] onehot);
    logic [1:0] nxt;
    nxt = CLS_P;
    if (onehot[CLS_P])   nxt = CLS_NP;
    if (onehot[CLS_NP])  nxt = CLS_CPL;
    if (onehot[CLS_CPL]) nxt = CLS_P;
    return nxt;
  endfunction

endpackage

// File: rtl/tx_fc_arbiter_rr_pick.sv
// Combinational three-way round-robin picker. The result is the first eligible
// class found when the search starts at ptr_i and wraps around P -> NP -> CPL.
module tx_fc_arbiter_rr_pick
  import tx_fc_arbiter_pkg::*;
(
  input  logic [2:0] elig_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] gnt_o,
  output logic       valid_o
);

  logic [2:0] rot;    // eligible vector rotated so bit 0 is the search start
  logic [2:0] first;  // lowest set bit of rot

  // Rotate, take the first set bit, then rotate back to class order.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    rot   = elig_i;
    gnt_o = '0;
    unique case (ptr_i)
      CLS_NP:  rot = {elig_i[CLS_P], elig_i[CLS_CPL], elig_i[CLS_NP]};
      CLS_CPL: rot = {elig_i[CLS_NP], elig_i[CLS_P], elig_i[CLS_CPL]};
      default: rot = elig_i;
    endcase

    first = rot & (~rot + 3'd1);

    unique case (ptr_i)
      CLS_NP:  gnt_o = {first[1], first[0], first[2]};
      CLS_CPL: gnt_o = {first[0], first[2], first[1]};
      default: gnt_o = first;
    endcase
  end

  assign valid_o = |elig_i;

endmodule

// File: rtl/tx_fc_arbiter.sv
// TX flow-control arbiter. It grants one of P/NP/CPL by round-robin when the
// class has enough header and data credits, holds the grant until the packet
// finishes, then waits REFRESH_CYCLES for the core's credit counters to settle.
module tx_fc_arbiter
  import tx_fc_arbiter_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 8  // legal range 1..255
) (
  input  logic        Arb_CLK,
  input  logic        Arb_RST,
  input  logic        Arb_Link_Up,
  input  logic [7:0]  Arb_fc_ph,
  input  logic [7:0]  Arb_fc_nph,
  input  logic [7:0]  Arb_fc_cplh,
  input  logic [11:0] Arb_fc_pd,
  input  logic [11:0] Arb_fc_npd,
  input  logic [11:0] Arb_fc_cpld,
  input  logic [2:0]  Arb_req,
  input  logic [9:0]  Arb_len_p,
  input  logic [9:0]  Arb_len_np,
  input  logic [9:0]  Arb_len_cpl,
  input  logic        Arb_done,
  output logic [2:0]  Arb_fc_sel,
  output logic [2:0]  Arb_gnt,
  output logic        Arb_busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(REFRESH_CYCLES - 1);

  arb_state_e state_q;
  logic [7:0] cnt_q;
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [2:0] gnt_q;
  logic       busy_q;
  logic [2:0] fc_sel_q;

  logic [8:0] need_p, need_np, need_cpl;
  logic [2:0] elig;
  logic [2:0] pick_gnt;
  logic       pick_valid;

  assign need_p   = data_credits_needed(Arb_len_p);
  assign need_np  = data_credits_needed(Arb_len_np);
  assign need_cpl = data_credits_needed(Arb_len_cpl);

  // A class is eligible when it requests, has a header credit and has enough
  // data credits. A header-only packet needs zero data credits.
  assign elig[CLS_P]   = Arb_req[CLS_P]   && (Arb_fc_ph   != 8'd0) &&
                         ({3'b000, need_p}   <= Arb_fc_pd);
  assign elig[CLS_NP]  = Arb_req[CLS_NP]  && (Arb_fc_nph  != 8'd0) &&
                         ({3'b000, need_np}  <= Arb_fc_npd);
  assign elig[CLS_CPL] = Arb_req[CLS_CPL] && (Arb_fc_cplh != 8'd0) &&
                         ({3'b000, need_cpl} <= Arb_fc_cpld);

  tx_fc_arbiter_rr_pick u_rr_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  assign ptr_d = next_class(pick_gnt);

  // Arbitration FSM. Every output comes from a register, and reset takes
  // priority over link-down, which takes priority over normal operation.
  always_ff @(posedge Arb_CLK) begin
    // NOTE: state registers use non-blocking assignments so that every
    // register in this block samples values from before the clock edge.
    if (Arb_RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= CLS_P;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      fc_sel_q <= FC_SEL_TX_AVAIL;
    end else if (!Arb_Link_Up) begin
      // Link loss aborts any packet. The round-robin position is kept.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_GRANT;
            gnt_q   <= pick_gnt;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_d;
          end
        end
        ST_GRANT: begin
          if (Arb_done) begin
            state_q <= ST_HOLD;
            gnt_q   <= '0;
            cnt_q   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Arb_gnt    = gnt_q;
  assign Arb_busy   = busy_q;
  assign Arb_fc_sel = fc_sel_q;

endmodule

// File: tb/tb_tx_fc_arbiter.sv
// Directed, table-driven bench for tx_fc_arbiter. Each record holds one input
// pattern, how many cycles to apply it, and the hand-computed outputs expected
// after every one of those cycles.
module tb_tx_fc_arbiter;

  localparam int REFRESH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        link;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic [2:0]  req;
  logic [9:0]  len_p, len_np, len_cpl;
  logic        done;
  logic [2:0]  fc_sel;
  logic [2:0]  gnt;
  logic        busy;

  always #5 clk = ~clk;

  tx_fc_arbiter #(.REFRESH_CYCLES(REFRESH)) dut (
    .Arb_CLK     (clk),
    .Arb_RST     (rst),
    .Arb_Link_Up (link),
    .Arb_fc_ph   (ph),
    .Arb_fc_nph  (nph),
    .Arb_fc_cplh (cplh),
    .Arb_fc_pd   (pd),
    .Arb_fc_npd  (npd),
    .Arb_fc_cpld (cpld),
    .Arb_req     (req),
    .Arb_len_p   (len_p),
    .Arb_len_np  (len_np),
    .Arb_len_cpl (len_cpl),
    .Arb_done    (done),
    .Arb_fc_sel  (fc_sel),
    .Arb_gnt     (gnt),
    .Arb_busy    (busy)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        link;
    logic [2:0]  req;
    logic        done;
    logic [9:0]  len_p, len_np, len_cpl;
    logic [7:0]  ph, nph, cplh;
    logic [11:0] pd, npd, cpld;
    int          reps;
    logic [2:0]  exp_gnt;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Credit and length context that add() copies into each new record.
  logic [9:0]  c_len_p, c_len_np, c_len_cpl;
  logic [7:0]  c_ph, c_nph, c_cplh;
  logic [11:0] c_pd, c_npd, c_cpld;

  int n_vec = 0;
  int n_err = 0;

  task automatic set_ample();
    c_len_p = 10'd4; c_len_np = 10'd4; c_len_cpl = 10'd4;
    c_ph = 8'd8; c_nph = 8'd8; c_cplh = 8'd8;
    c_pd = 12'd100; c_npd = 12'd100; c_cpld = 12'd100;
  endtask

  task automatic add(input string nm, input logic r, input logic l,
                     input logic [2:0] rq, input logic d, input int reps,
                     input logic [2:0] eg, input logic eb);
    vec_t v;
    v.name = nm; v.rst = r; v.link = l; v.req = rq; v.done = d;
    v.len_p = c_len_p; v.len_np = c_len_np; v.len_cpl = c_len_cpl;
    v.ph = c_ph; v.nph = c_nph; v.cplh = c_cplh;
    v.pd = c_pd; v.npd = c_npd; v.cpld = c_cpld;
    v.reps = reps; v.exp_gnt = eg; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // done pulse in GRANT, REFRESH-1 further HOLD cycles, then one IDLE cycle.
  task automatic add_release(input logic [2:0] rq);
    add("done",      1'b0, 1'b1, rq, 1'b1, 1,           3'b000, 1'b1);
    add("hold",      1'b0, 1'b1, rq, 1'b0, REFRESH - 1, 3'b000, 1'b1);
    add("hold_exit", 1'b0, 1'b1, rq, 1'b0, 1,           3'b000, 1'b0);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; link = 1'b0; req = '0; done = 1'b0;
    len_p = '0; len_np = '0; len_cpl = '0;
    ph = '0; nph = '0; cplh = '0; pd = '0; npd = '0; cpld = '0;

    // Single P request: len 8 needs 2 data credits, pd=2 is just enough.
    c_len_p = 10'd8; c_len_np = 10'd0; c_len_cpl = 10'd0;
    c_ph = 8'd4; c_nph = 8'd0; c_cplh = 8'd0;
    c_pd = 12'd2; c_npd = 12'd0; c_cpld = 12'd0;
    add("reset",         1'b1, 1'b0, 3'b000, 1'b0, 2, 3'b000, 1'b0);
    add("no_link",       1'b0, 1'b0, 3'b001, 1'b0, 2, 3'b000, 1'b0);
    add("first_gnt_p",   1'b0, 1'b1, 3'b001, 1'b0, 1, 3'b001, 1'b1);
    add("gnt_held",      1'b0, 1'b1, 3'b000, 1'b0, 3, 3'b001, 1'b1);
    add("done_p",        1'b0, 1'b1, 3'b000, 1'b1, 1, 3'b000, 1'b1);
    add("hold_done_ign", 1'b0, 1'b1, 3'b001, 1'b1, REFRESH - 1, 3'b000, 1'b1);
    add("hold_exit",     1'b0, 1'b1, 3'b001, 1'b0, 1, 3'b000, 1'b0);
    add("regrant_p",     1'b0, 1'b1, 3'b001, 1'b0, 1, 3'b001, 1'b1);
    // Reset in HOLD while the counter reads 5.
    add("done_p2",       1'b0, 1'b1, 3'b000, 1'b1, 1, 3'b000, 1'b1);
    add("hold_to_5",     1'b0, 1'b1, 3'b000, 1'b0, 2, 3'b000, 1'b1);
    set_ample();
    add("rst_in_hold",   1'b1, 1'b1, 3'b111, 1'b1, 1, 3'b000, 1'b0);

    // Round-robin order P, NP, CPL, P after reset.
    add("rr_p",          1'b0, 1'b1, 3'b111, 1'b0, 1, 3'b001, 1'b1);
    add_release(3'b111);
    add("rr_np",         1'b0, 1'b1, 3'b111, 1'b0, 1, 3'b010, 1'b1);
    add_release(3'b111);
    add("rr_cpl",        1'b0, 1'b1, 3'b111, 1'b0, 1, 3'b100, 1'b1);
    add_release(3'b111);
    add("rr_p_again",    1'b0, 1'b1, 3'b111, 1'b0, 1, 3'b001, 1'b1);
    add_release(3'b000);

    // Header-only NP needs no data credit, but it does need a header credit.
    c_len_np = 10'd0; c_npd = 12'd0; c_nph = 8'd1;
    add("np_hdr_only",   1'b0, 1'b1, 3'b010, 1'b0, 1, 3'b010, 1'b1);
    add_release(3'b000);
    c_nph = 8'd0;
    add("np_no_hdr",     1'b0, 1'b1, 3'b010, 1'b0, 3, 3'b000, 1'b0);

    // Link drop during GRANT; a later done must be ignored.
    set_ample();
    add("cpl_gnt",       1'b0, 1'b1, 3'b100, 1'b0, 1, 3'b100, 1'b1);
    add("link_drop",     1'b0, 1'b0, 3'b100, 1'b0, 1, 3'b000, 1'b0);
    add("done_ignored",  1'b0, 1'b0, 3'b100, 1'b1, 2, 3'b000, 1'b0);

    // P needs ceil(9/4)=3 credits but has 2, so NP goes ahead.
    c_len_p = 10'd9; c_pd = 12'd2;
    add("p_skipped",     1'b0, 1'b1, 3'b011, 1'b0, 1, 3'b010, 1'b1);
    add_release(3'b011);
    c_pd = 12'd3;
    add("p_after_raise", 1'b0, 1'b1, 3'b011, 1'b0, 1, 3'b001, 1'b1);

    // Link drop during HOLD clears the counter, so the next grant comes at once.
    set_ample();
    add("done_p3",       1'b0, 1'b1, 3'b000, 1'b1, 1, 3'b000, 1'b1);
    add("hold_short",    1'b0, 1'b1, 3'b000, 1'b0, 2, 3'b000, 1'b1);
    add("link_drop_hold",1'b0, 1'b0, 3'b000, 1'b0, 1, 3'b000, 1'b0);
    add("relink_np",     1'b0, 1'b1, 3'b011, 1'b0, 1, 3'b010, 1'b1);
    add_release(3'b000);

    // Maximum length 1023 DW needs 256 data credits.
    c_len_cpl = 10'd1023; c_cpld = 12'd255;
    add("cpl_256_short", 1'b0, 1'b1, 3'b100, 1'b0, 2, 3'b000, 1'b0);
    c_cpld = 12'd256;
    add("cpl_256_ok",    1'b0, 1'b1, 3'b100, 1'b0, 1, 3'b100, 1'b1);
    // Credit and request changes in GRANT leave the grant alone.
    c_cplh = 8'd0;
    add("gnt_ignores",   1'b0, 1'b1, 3'b000, 1'b0, 2, 3'b100, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(negedge clk);
        rst = vecs[i].rst; link = vecs[i].link; req = vecs[i].req;
        done = vecs[i].done;
        len_p = vecs[i].len_p; len_np = vecs[i].len_np; len_cpl = vecs[i].len_cpl;
        ph = vecs[i].ph; nph = vecs[i].nph; cplh = vecs[i].cplh;
        pd = vecs[i].pd; npd = vecs[i].npd; cpld = vecs[i].cpld;
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d].gnt", vecs[i].name, r), {5'b0, gnt}, {5'b0, vecs[i].exp_gnt});
        check($sformatf("%s[%0d].busy", vecs[i].name, r), {7'b0, busy}, {7'b0, vecs[i].exp_busy});
        check($sformatf("%s[%0d].fc_sel", vecs[i].name, r), {5'b0, fc_sel}, 8'h04);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_fc_arbiter.md
TX_FC_ARBITER -- requirements
Module: tx_fc_arbiter

Interface
REQ-001 Parameter REFRESH_CYCLES, default 8, post-packet hold-off (cycles) while core credit counters update; legal range 1..255.
REQ-002 Arb_CLK  input  1  single clock; all logic rising-edge synchronous.
REQ-003 Arb_RST  input  1  synchronous, active-high reset.
REQ-004 Arb_Link_Up  input  1  core link-up; low gates off all grants.
REQ-005 Arb_fc_ph / Arb_fc_nph / Arb_fc_cplh  input  8 each  available header credits (posted/non-posted/completion).
REQ-006 Arb_fc_pd / Arb_fc_npd / Arb_fc_cpld  input  12 each  available data credits (1 credit = 4 DW).
REQ-007 Arb_req  input  3  request per class: [0]=P, [1]=NP, [2]=CPL.
REQ-008 Arb_len_p / Arb_len_np / Arb_len_cpl  input  10 each  payload length in DW; 0 = header-only.
REQ-009 Arb_done  input  1  one-cycle pulse from TX engine at last beat of granted packet.
REQ-010 Arb_fc_sel  output  3  flow-control select to core.
REQ-011 Arb_gnt  output  3  registered one-hot grant, same bit order as Arb_req.
REQ-012 Arb_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States IDLE, GRANT, HOLD; all outputs registered.
REQ-014 Data credits needed = ceil(len/4), computed 9-bit, no overflow (max 256); len=0 needs 0 data credits.
REQ-015 Class eligible when Arb_req bit=1 AND header credits >= 1 AND data credits >= needed (unsigned compare, 12-bit).
REQ-016 IDLE: if Arb_Link_Up=1 and any class eligible, select by round-robin, next cycle Arb_gnt = that one-hot bit, state GRANT.
REQ-017 Round-robin search starts at class after last granted (order P->NP->CPL->P); pointer updates only on grant.
REQ-018 Ineligible requesting class is skipped, not waited on; no eligible class -> remain IDLE, Arb_gnt=0.
REQ-019 GRANT: Arb_gnt held constant until Arb_done; request/credit changes ignored while in GRANT.
REQ-020 GRANT with Arb_done=1: next cycle Arb_gnt=0, state HOLD, counter loaded REFRESH_CYCLES-1.
REQ-021 HOLD: counter decrements each cycle; at 0 next state IDLE; no grant issued during HOLD (total hold = REFRESH_CYCLES cycles).
REQ-022 Arb_done outside GRANT ignored.
REQ-023 Arb_Link_Up=0 in any state: next cycle state IDLE, Arb_gnt=0, counter cleared; RR pointer retained.
REQ-024 Grant-to-new-grant minimum spacing: done cycle +1 (HOLD entry) + REFRESH_CYCLES + 1 (IDLE evaluate).
REQ-025 Arb_fc_sel driven 3'b100 (transmit-available view) at all times after reset.

Reset
REQ-026 Arb_RST=1 sampled on edge: state IDLE, Arb_gnt=3'b000, Arb_busy=0, counter=0, RR pointer=P first, Arb_fc_sel=3'b100.
REQ-027 Reset mid-GRANT or mid-HOLD aborts immediately; no grant in the cycle after reset release.
REQ-028 Reset dominates Arb_Link_Up and Arb_done.

Structure
REQ-029 Shared package holds class index constants (P=0, NP=1, CPL=2), FC_SEL_TX_AVAIL=3'b100, state encoding, CREDIT_DW=4.
REQ-030 One sub-module rr_pick: combinational 3-way round-robin picker (eligible vector + pointer -> one-hot, valid).

Verification
REQ-031 Reset then Link_Up=1, req=3'b001, len_p=8, ph=4, pd=2 -> gnt=3'b001 one cycle later, busy=1.
REQ-032 req=3'b111, all credits ample, done after each grant -> grant order P, NP, CPL, P; REFRESH_CYCLES+1 idle cycles between done and next gnt.
REQ-033 req=3'b011, len_p=9, pd=2 (needs 3) -> P skipped, gnt=3'b010; raise pd=3 -> P granted next round.
REQ-034 len_np=0, npd=0, nph=1 -> NP granted; nph=0 -> no grant, busy=0.
REQ-035 Link_Up dropped during GRANT -> gnt=0 next cycle, state IDLE, subsequent done ignored.
REQ-036 Arb_RST asserted during HOLD (counter=5) -> next cycle gnt=0, busy=0, fc_sel=3'b100, RR restarts at P.
